// File: rtl/io_pkg.sv
// Shared register-map constants and field positions for the memory-mapped I/O bank.
package io_pkg;
  localparam int ADDR_DIG0 = 0;
  localparam int ADDR_SW   = 16;
  localparam int ADDR_CHG  = 17;
  localparam int ADDR_CTRL = 18;
  localparam int ADDR_TICK = 19;

  localparam int DIG_W         = 6;
  localparam int DIG_BLANK_BIT = 4;
  localparam int DIG_BLINK_BIT = 5;

  localparam logic [DIG_W-1:0] DIG_RST   = 6'b01_0000;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
    endcase
  end
endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: seven-segment digits with blank/blink, synchronised switches
// with sticky W1C change flags and an interrupt, and a registered read port.
module io_port_bank
  import io_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SW_WIDTH   = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    write_enable,
  input  logic [31:0]             data_in,
  input  logic [SW_WIDTH-1:0]     io_in,
  output logic [7*NUM_DIGITS-1:0] io_out,
  output logic [31:0]             io_data_out,
  output logic                    sw_irq
);
  localparam int TICK_W = $clog2(BLINK_DIV);

  logic [NUM_DIGITS-1:0][DIG_W-1:0] dig_q, dig_d;
  logic [1:0]                       ctrl_q, ctrl_d;
  logic [SW_WIDTH-1:0]              s1_q, s2_q, prev_q, chg_q, chg_d, chg_clr;
  logic [TICK_W-1:0]                tick_q, tick_d;
  logic                             phase_q, phase_d;
  logic [31:0]                      rdata;
  logic                             wr_chg, wr_ctrl;
  logic                             unused_data;

  // Upper write-data bits have no storage; fold them into a sink.
  assign unused_data = ^data_in;

  assign wr_chg  = write_enable && (addr == ADDR_WIDTH'(ADDR_CHG));
  assign wr_ctrl = write_enable && (addr == ADDR_WIDTH'(ADDR_CTRL));

  always_comb begin
    dig_d = dig_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (write_enable && (addr == ADDR_WIDTH'(ADDR_DIG0 + k)))
        dig_d[k] = data_in[DIG_W-1:0];
  end

  assign ctrl_d = wr_ctrl ? data_in[1:0] : ctrl_q;

  // A fresh edge on a bit re-sets it even if the same cycle writes 1 to clear it.
  assign chg_clr = wr_chg ? data_in[SW_WIDTH-1:0] : '0;
  assign chg_d   = (chg_q & ~chg_clr) | (s2_q ^ prev_q);
  assign sw_irq  = |chg_q;

  always_comb begin
    tick_d  = '0;
    phase_d = 1'b0;
    if (ctrl_q[1]) begin
      if (tick_q == TICK_W'(BLINK_DIV - 1)) begin
        tick_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tick_d  = tick_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (addr == ADDR_WIDTH'(ADDR_DIG0 + k)) rdata[DIG_W-1:0] = dig_q[k];
    if (addr == ADDR_WIDTH'(ADDR_SW))   rdata[SW_WIDTH-1:0] = s2_q;
    if (addr == ADDR_WIDTH'(ADDR_CHG))  rdata[SW_WIDTH-1:0] = chg_q;
    if (addr == ADDR_WIDTH'(ADDR_CTRL)) rdata[1:0]          = ctrl_q;
    if (addr == ADDR_WIDTH'(ADDR_TICK)) rdata[TICK_W-1:0]   = tick_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dig_q       <= {NUM_DIGITS{DIG_RST}};
      ctrl_q      <= 2'b11;
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      chg_q       <= '0;
      tick_q      <= '0;
      phase_q     <= 1'b0;
      io_data_out <= '0;
    end else begin
      dig_q       <= dig_d;
      ctrl_q      <= ctrl_d;
      s1_q        <= io_in;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      chg_q       <= chg_d;
      tick_q      <= tick_d;
      phase_q     <= phase_d;
      io_data_out <= rdata;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic [6:0] seg;
    logic       dark;
    hex_to_seg7 u_dec (.hex_i(dig_q[k][3:0]), .seg_o(seg));
    assign dark = !ctrl_q[0] || dig_q[k][DIG_BLANK_BIT] ||
                  (dig_q[k][DIG_BLINK_BIT] && ctrl_q[1] && phase_q);
    assign io_out[7*k +: 7] = dark ? SEG_BLANK : seg;
  end
endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with a short blink period.
module tb_io_port_bank;
  localparam int ND = 6;
  localparam int SW = 10;
  localparam int AW = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   addr = '0;
  logic            write_enable = 1'b0;
  logic [31:0]     data_in = '0;
  logic [SW-1:0]   io_in = '0;
  logic [7*ND-1:0] io_out;
  logic [31:0]     io_data_out;
  logic            sw_irq;
  logic [31:0]     rv;
  int              tests = 0;
  int              fails = 0;

  io_port_bank #(.NUM_DIGITS(ND), .SW_WIDTH(SW), .ADDR_WIDTH(AW), .BLINK_DIV(4)) dut (
    .clock(clock), .reset(reset), .addr(addr), .write_enable(write_enable),
    .data_in(data_in), .io_in(io_in), .io_out(io_out),
    .io_data_out(io_data_out), .sw_irq(sw_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both tasks start and end on a falling edge.
  task automatic wr(input int a, input logic [31:0] d);
    addr = AW'(a); data_in = d; write_enable = 1'b1;
    @(negedge clock);
    write_enable = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    addr = AW'(a);
    @(negedge clock);
    v = io_data_out;
  endtask

  initial begin
    // T1 reset
    repeat (2) @(negedge clock);
    check("rst_io_out", 64'(io_out), {22'd0, {42{1'b1}}});
    check("rst_rdata", 64'(io_data_out), 64'd0);
    check("rst_irq", 64'(sw_irq), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    rd(18, rv); check("rst_ctrl", 64'(rv), 64'd3);

    // T2 digit write
    wr(2, 32'h05);
    rd(2, rv); check("dig2_read", 64'(rv), 64'h5);
    check("dig2_seg", 64'(io_out[20:14]), 64'h12);
    check("dig0_dark", 64'(io_out[6:0]), 64'h7F);

    // T3 switch change and W1C
    io_in = 10'h201;
    repeat (3) @(negedge clock);
    rd(16, rv); check("sw_read", 64'(rv), 64'h201);
    rd(17, rv); check("chg_read", 64'(rv), 64'h201);
    check("irq_set", 64'(sw_irq), 64'd1);
    wr(17, 32'h001);
    check("rd_pre_write", 64'(io_data_out), 64'h201);
    rd(17, rv); check("chg_w1c", 64'(rv), 64'h200);
    check("irq_still", 64'(sw_irq), 64'd1);

    // T4 set beats clear on bit 9
    wr(17, 32'h200);
    rd(17, rv); check("chg_clr9", 64'(rv), 64'h0);
    io_in = 10'h001;
    repeat (2) @(negedge clock);
    wr(17, 32'h200);
    rd(17, rv); check("set_wins", 64'(rv), 64'h200);
    wr(17, 32'h3FF);
    rd(17, rv); check("chg_all_clr", 64'(rv), 64'h0);
    check("irq_clr", 64'(sw_irq), 64'd0);

    // T5 blink: hold counter, arm digit 0, then release on a known edge
    wr(18, 32'h1);
    wr(0, 32'h28);
    check("dig0_noblink", 64'(io_out[6:0]), 64'h00);
    wr(18, 32'h3);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("blink_%0d", i), 64'(io_out[6:0]), ((i / 4) % 2 == 1) ? 64'h7F : 64'h00);
      @(negedge clock);
    end
    wr(18, 32'h1);
    repeat (5) @(negedge clock);
    check("blink_off_seg", 64'(io_out[6:0]), 64'h00);
    rd(19, rv); check("tick_held", 64'(rv), 64'h0);
    wr(18, 32'h0);
    check("disp_off", 64'(io_out[20:14]), 64'h7F);
    wr(18, 32'h3);

    // T6 illegal accesses
    wr(7, 32'h0F);
    rd(7, rv); check("addr7_unmapped", 64'(rv), 64'h0);
    wr(16, 32'h3FF);
    rd(16, rv); check("sw_ro", 64'(rv), 64'h001);
    rd(25, rv); check("addr25", 64'(rv), 64'h0);
    wr(1, 32'hFFFF_FFFF);
    rd(1, rv); check("dig1_fields", 64'(rv), 64'h3F);
    rd(2, rv); check("dig2_kept", 64'(rv), 64'h5);

    // mid-operation reset with a pending flag and non-zero read data
    io_in = 10'h000;
    repeat (4) @(negedge clock);
    check("irq_pre_rst", 64'(sw_irq), 64'd1);
    rd(0, rv); check("dig0_pre_rst", 64'(rv), 64'h28);
    reset = 1'b1;
    #1;
    check("mid_rst_io_out", 64'(io_out), {22'd0, {42{1'b1}}});
    check("mid_rst_rdata", 64'(io_data_out), 64'd0);
    check("mid_rst_irq", 64'(sw_irq), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    rd(18, rv); check("post_rst_ctrl", 64'(rv), 64'd3);
    rd(0, rv); check("post_rst_dig0", 64'(rv), 64'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
